// File: rtl/result_stream_pkg.sv
// Shared definitions for the result egress path: cfg address map, FSM states
// and the length-check helper.
package result_stream_pkg;

    localparam logic [4:0] CFG_RSLT = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } rslt_state_e;

    // A word's rslt_last flag must agree with whether the word count says it is the final word.
    function automatic logic len_mismatch(input logic final_word, input logic last_flag);
        return final_word != last_flag;
    endfunction

endpackage

// File: rtl/result_shift.sv
// Down-shift serialiser: holds one result word and emits it as R stream beats,
// least-significant slice first, with val/rdy handshake and end-of-transfer last.
module result_shift #(
    parameter int WORD_W = 64,
    parameter int STR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              end_in,
    output logic [STR_W-1:0]  str_bus,
    output logic              str_last,
    output logic              str_val,
    input  logic              str_rdy,
    output logic              beat_done
);

    localparam int R   = WORD_W / STR_W;
    localparam int BCW = (R > 1) ? $clog2(R) : 1;

    logic [WORD_W-1:0] shift_r;
    logic [BCW-1:0]    beat_cnt_r;
    logic              val_r;
    logic              end_r;
    logic              final_beat_s;

    assign final_beat_s = (beat_cnt_r == '0);
    assign beat_done    = val_r & str_rdy & final_beat_s;
    assign str_bus      = shift_r[STR_W-1:0];
    assign str_val      = val_r;
    assign str_last     = val_r & end_r & final_beat_s;

    // Word capture has priority so a new word can land on the final-beat accept cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r    <= '0;
            beat_cnt_r <= '0;
            val_r      <= 1'b0;
            end_r      <= 1'b0;
        end else if (load) begin
            shift_r    <= word;
            beat_cnt_r <= BCW'(R - 1);
            val_r      <= 1'b1;
            end_r      <= end_in;
        end else if (val_r && str_rdy) begin
            if (final_beat_s) begin
                val_r <= 1'b0;
            end else begin
                shift_r    <= shift_r >> STR_W;
                beat_cnt_r <= beat_cnt_r - BCW'(1);
            end
        end
    end

endmodule

// File: rtl/result_stream.sv
// Result egress: accepts wide result words, serialises them to host stream beats,
// frames the transfer against the armed word count and reports done/mismatch.
module result_stream
    import result_stream_pkg::*;
#(
    parameter int CFG_DWIDTH     = 32,
    parameter int CFG_AWIDTH     = 5,
    parameter int STR_RSLT_WIDTH = 16,
    parameter int GROUP_NB       = 4,
    parameter int IMG_WIDTH      = 16,
    parameter int MEM_AWIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] rslt_bus,
    input  logic                          rslt_last,
    input  logic                          rslt_val,
    output logic                          rslt_rdy,
    output logic [STR_RSLT_WIDTH-1:0]     str_rslt_bus,
    output logic                          str_rslt_last,
    output logic                          str_rslt_val,
    input  logic                          str_rslt_rdy,
    output logic                          rslt_done,
    output logic                          rslt_err
);

    localparam int WORD_W = GROUP_NB * IMG_WIDTH;

    rslt_state_e           state_r;
    logic [MEM_AWIDTH-1:0] word_cnt_r;
    logic [MEM_AWIDTH-1:0] cnt_eff_s;
    logic [MEM_AWIDTH-1:0] arm_n_s;
    logic                  err_r;
    logic                  done_r;
    logic                  arm_s;
    logic                  rdy_s;
    logic                  accept_s;
    logic                  final_word_s;
    logic                  end_s;
    logic                  beat_done_s;
    logic                  last_out_s;
    logic                  unused_cfg_s;

    assign arm_n_s      = cfg_data[MEM_AWIDTH-1:0];
    assign unused_cfg_s = ^cfg_data[CFG_DWIDTH-1:MEM_AWIDTH];
    assign arm_s        = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_RSLT)) && (arm_n_s != '0);

    // Ready in LOAD, and on a non-ending final-beat accept so back-to-back words see no bubble.
    always_comb begin
        rdy_s = 1'b0;
        if (state_r == ST_LOAD) begin
            rdy_s = 1'b1;
        end else if (state_r == ST_SHIFT) begin
            rdy_s = beat_done_s & ~last_out_s;
        end else begin
            rdy_s = 1'b0;
        end
    end

    // In SHIFT the count is decremented on the same edge the next word is taken.
    assign cnt_eff_s    = (state_r == ST_SHIFT) ? (word_cnt_r - MEM_AWIDTH'(1)) : word_cnt_r;
    assign final_word_s = (cnt_eff_s == MEM_AWIDTH'(1));
    assign end_s        = final_word_s | rslt_last;
    assign accept_s     = rslt_val & rdy_s;

    assign rslt_rdy      = rdy_s;
    assign str_rslt_last = last_out_s;
    assign rslt_done     = done_r;
    assign rslt_err      = err_r;

    result_shift #(
        .WORD_W (WORD_W),
        .STR_W  (STR_RSLT_WIDTH)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .word      (rslt_bus),
        .end_in    (end_s),
        .str_bus   (str_rslt_bus),
        .str_last  (last_out_s),
        .str_val   (str_rslt_val),
        .str_rdy   (str_rslt_rdy),
        .beat_done (beat_done_s)
    );

    // Transfer FSM with word counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            word_cnt_r <= '0;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arm_s) begin
                        word_cnt_r <= arm_n_s;
                        err_r      <= 1'b0;
                        state_r    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        err_r   <= err_r | len_mismatch(final_word_s, rslt_last);
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (beat_done_s) begin
                        if (last_out_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            word_cnt_r <= cnt_eff_s;
                            if (accept_s) begin
                                err_r <= err_r | len_mismatch(final_word_s, rslt_last);
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_stream.sv
// Self-checking bench for result_stream: directed and randomized transfers compared
// against a word/beat-level reference model, plus a R=1 instance for throughput.
module tb_result_stream;
    import result_stream_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic [63:0] rslt_bus;
    logic        rslt_last, rslt_val, rslt_rdy;
    logic [15:0] str_rslt_bus;
    logic        str_rslt_last, str_rslt_val, str_rslt_rdy;
    logic        rslt_done, rslt_err;

    logic [31:0] cfg_data_w;
    logic [4:0]  cfg_addr_w;
    logic        cfg_valid_w;
    logic [63:0] rslt_bus_w;
    logic        rslt_last_w, rslt_val_w, rslt_rdy_w;
    logic [63:0] str_rslt_bus_w;
    logic        str_rslt_last_w, str_rslt_val_w;
    logic        str_rslt_rdy_w;
    logic        rslt_done_w, rslt_err_w;

    result_stream dut (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .rslt_bus(rslt_bus), .rslt_last(rslt_last), .rslt_val(rslt_val), .rslt_rdy(rslt_rdy),
        .str_rslt_bus(str_rslt_bus), .str_rslt_last(str_rslt_last), .str_rslt_val(str_rslt_val),
        .str_rslt_rdy(str_rslt_rdy), .rslt_done(rslt_done), .rslt_err(rslt_err)
    );

    result_stream #(.STR_RSLT_WIDTH(64)) dut_w (
        .clk(clk), .rst(rst), .cfg_data(cfg_data_w), .cfg_addr(cfg_addr_w), .cfg_valid(cfg_valid_w),
        .rslt_bus(rslt_bus_w), .rslt_last(rslt_last_w), .rslt_val(rslt_val_w), .rslt_rdy(rslt_rdy_w),
        .str_rslt_bus(str_rslt_bus_w), .str_rslt_last(str_rslt_last_w), .str_rslt_val(str_rslt_val_w),
        .str_rslt_rdy(str_rslt_rdy_w), .rslt_done(rslt_done_w), .rslt_err(rslt_err_w)
    );

    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    logic [16:0] got[$];
    logic [16:0] exp_q[$];
    int          done_cnt = 0;
    int          stall_viol = 0;
    logic [63:0] got_w[$];
    logic        last_w[$];
    int          cyc_w[$];
    int          done_cnt_w = 0;
    logic [63:0] w_a[8];
    bit          l_a[8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Host ready driver: 0 = always ready, 1 = toggle, other = random.
    initial begin
        str_rslt_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: str_rslt_rdy = 1'b1;
                1: str_rslt_rdy = ~str_rslt_rdy;
                default: str_rslt_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Beat monitor for the R=4 instance, including stall stability.
    initial begin
        logic        prev_stall;
        logic [15:0] prev_bus;
        logic        prev_last;
        prev_stall = 1'b0;
        prev_bus   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(str_rslt_val && str_rslt_bus == prev_bus && str_rslt_last == prev_last))
                    stall_viol++;
                if (str_rslt_val && str_rslt_rdy)
                    got.push_back({str_rslt_last, str_rslt_bus});
                if (rslt_done)
                    done_cnt++;
                prev_stall = str_rslt_val && !str_rslt_rdy;
                prev_bus   = str_rslt_bus;
                prev_last  = str_rslt_last;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && str_rslt_val_w && str_rslt_rdy_w) begin
                got_w.push_back(str_rslt_bus_w);
                last_w.push_back(str_rslt_last_w);
                cyc_w.push_back(cyc);
            end
            if (!rst && rslt_done_w)
                done_cnt_w++;
        end
    end

    task automatic arm(input logic [31:0] n, input logic [4:0] a);
        cfg_data  = n;
        cfg_addr  = a;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input bit lst, input int gap);
        bit acc;
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rslt_bus  = d;
        rslt_last = lst;
        rslt_val  = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rslt_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        rslt_val  = 1'b0;
        rslt_last = 1'b0;
        check("word_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt), 64'd1);
    endtask

    // Reference model: words are cut into four 16-bit slices LSB first; the transfer
    // ends at the first word flagged last or at word n; error when those disagree.
    task automatic run_xfer(input string tag, input int n, input bit gaps, input bit midarm);
        int  endk;
        bit  err_exp;
        got.delete();
        exp_q.delete();
        done_cnt   = 0;
        stall_viol = 0;
        endk = -1;
        for (int k = 0; k < n && endk < 0; k++) begin
            bit ending;
            ending = (k == n - 1) || l_a[k];
            for (int j = 0; j < 4; j++)
                exp_q.push_back({ending && (j == 3), w_a[k][16*j +: 16]});
            if (ending) endk = k;
        end
        err_exp = (endk != n - 1) || !l_a[endk];
        arm(32'(n), CFG_RSLT);
        for (int k = 0; k <= endk; k++) begin
            send_word(w_a[k], l_a[k], gaps ? $urandom_range(0, 2) : 0);
            if (midarm && k == 0) arm(32'd5, CFG_RSLT);
        end
        wait_done();
        check({tag, "_nbeats"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        check({tag, "_err"}, 64'(rslt_err), 64'(err_exp));
        check({tag, "_stall"}, 64'(stall_viol), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] w6[4];
        int          idx, n, rdy_drop;
        bit          acc;

        rst = 1'b1;
        cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;
        rslt_bus = '0; rslt_last = 1'b0; rslt_val = 1'b0;
        cfg_data_w = '0; cfg_addr_w = '0; cfg_valid_w = 1'b0;
        rslt_bus_w = '0; rslt_last_w = 1'b0; rslt_val_w = 1'b0;
        str_rslt_rdy_w = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 64'(rslt_rdy), 64'd0);
        check("rst_val", 64'(str_rslt_val), 64'd0);
        check("rst_last", 64'(str_rslt_last), 64'd0);
        check("rst_bus", 64'(str_rslt_bus), 64'd0);
        check("rst_done", 64'(rslt_done), 64'd0);
        check("rst_err", 64'(rslt_err), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_rdy", 64'(rslt_rdy), 64'd0);

        // Zero count and foreign addresses must not arm.
        arm(32'd0, CFG_RSLT);
        @(posedge clk); #1;
        check("arm_n0_ignored", 64'(rslt_rdy), 64'd0);
        arm(32'd2, CFG_RSLT + 5'd1);
        @(posedge clk); #1;
        check("arm_addr_ignored", 64'(rslt_rdy), 64'd0);

        // Test 1: two words, host always ready.
        rdy_mode = 0;
        w_a[0] = 64'h4444_3333_2222_1111; l_a[0] = 1'b0;
        w_a[1] = 64'h8888_7777_6666_5555; l_a[1] = 1'b1;
        run_xfer("t1", 2, 1'b0, 1'b0);
        if (got.size() == 8) begin
            check("t1_first", 64'(got[0]), 64'h0_1111);
            check("t1_last", 64'(got[7]), 64'h1_8888);
            check("t1_mid", 64'(got[4]), 64'h0_5555);
        end

        // Test 2: same data under toggled host ready.
        rdy_mode = 1;
        run_xfer("t2", 2, 1'b0, 1'b0);

        // Test 3: early last -> error, then re-arm clears it.
        rdy_mode = 0;
        w_a[0] = {$urandom, $urandom}; l_a[0] = 1'b0;
        w_a[1] = {$urandom, $urandom}; l_a[1] = 1'b1;
        run_xfer("t3", 3, 1'b0, 1'b0);
        check("t3_idle", 64'(rslt_rdy), 64'd0);
        arm(32'd1, CFG_RSLT);
        check("t3_rearm_err", 64'(rslt_err), 64'd0);
        check("t3_rearm_rdy", 64'(rslt_rdy), 64'd1);
        got.delete();
        done_cnt = 0;
        send_word(64'h0123_4567_89ab_cdef, 1'b1, 0);
        wait_done();
        check("t3b_nbeats", 64'(got.size()), 64'd4);
        check("t3b_err", 64'(rslt_err), 64'd0);

        // Test 4: single word without last, arm attempt mid-transfer.
        w_a[0] = {$urandom, $urandom}; l_a[0] = 1'b0;
        run_xfer("t4", 1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("t4_midarm_ignored", 64'(rslt_rdy), 64'd0);

        // Test 5: reset during beat 2 aborts the transfer.
        got.delete();
        done_cnt = 0;
        arm(32'd1, CFG_RSLT);
        send_word(64'hdead_beef_cafe_f00d, 1'b1, 0);
        n = 0;
        while (got.size() < 1 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        rst = 1'b1;
        #1;
        check("t5_val", 64'(str_rslt_val), 64'd0);
        check("t5_bus", 64'(str_rslt_bus), 64'd0);
        check("t5_last", 64'(str_rslt_last), 64'd0);
        check("t5_rdy", 64'(rslt_rdy), 64'd0);
        check("t5_done", 64'(rslt_done), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t5_idle", 64'(rslt_rdy), 64'd0);
        w_a[0] = {$urandom, $urandom}; l_a[0] = 1'b1;
        run_xfer("t5b", 1, 1'b0, 1'b0);

        // Randomized transfers with random host ready and word gaps.
        rdy_mode = 2;
        for (int it = 0; it < 6; it++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                w_a[k] = {$urandom, $urandom};
                l_a[k] = ($urandom_range(0, 3) == 0) || (k == nw - 1 && $urandom_range(0, 1) == 1);
            end
            run_xfer($sformatf("rnd%0d", it), nw, 1'b1, 1'b0);
        end

        // Test 6: R=1 instance, four back-to-back words.
        for (int k = 0; k < 4; k++) w6[k] = {$urandom, $urandom};
        cfg_data_w = 32'd4; cfg_addr_w = CFG_RSLT; cfg_valid_w = 1'b1;
        @(posedge clk); #1;
        cfg_valid_w = 1'b0;
        rslt_bus_w = w6[0]; rslt_last_w = 1'b0; rslt_val_w = 1'b1;
        idx = 0; n = 0; rdy_drop = 0;
        while (idx < 4 && n < 50) begin
            @(negedge clk);
            acc = rslt_rdy_w;
            if (!acc && idx > 0) rdy_drop++;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    rslt_bus_w  = w6[idx];
                    rslt_last_w = (idx == 3);
                end
            end
            n++;
        end
        rslt_val_w = 1'b0;
        rslt_last_w = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_nbeats", 64'(got_w.size()), 64'd4);
        for (int i = 0; i < 4 && i < got_w.size(); i++) begin
            check($sformatf("t6_beat%0d", i), got_w[i], w6[i]);
            check($sformatf("t6_last%0d", i), 64'(last_w[i]), 64'(i == 3));
            check($sformatf("t6_cycle%0d", i), 64'(cyc_w[i] - cyc_w[0]), 64'(i));
        end
        check("t6_rdy_held", 64'(rdy_drop), 64'd0);
        check("t6_err", 64'(rslt_err_w), 64'd0);
        check("t6_done", 64'(done_cnt_w), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
